// File: rtl/ob_mtr_reissue.sv
// Reissue merge point between the conditional table's matured-command port and the
// fresh ingress stream, producing one registered issue stream for the book pipeline.
package ob_pkg;
    typedef struct packed {
        logic [3:0]  op;
        logic [11:0] arg;
    } cmd_t;
endpackage

module ob_mtr_reissue #(
    parameter int FIFO_N     = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           mtr_vld_r,
    input  ob_pkg::cmd_t                   mtr_r,
    output logic                           mtr_accept,
    input  logic                           in_vld,
    input  ob_pkg::cmd_t                   in_cmd,
    output logic                           in_rdy,
    output logic                           issue_vld_r,
    output ob_pkg::cmd_t                   issue_cmd_r,
    input  logic                           issue_accept,
    input  logic                           flush,
    output logic [$clog2(FIFO_N+1)-1:0]    occ_r,
    output logic                           full_r
);
    localparam int OCC_W = $clog2(FIFO_N + 1);
    localparam int PTR_W = $clog2(FIFO_N);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {PRI_MTR = 1'b0, PRI_IN = 1'b1} arb_state_t;

    arb_state_t         r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    ob_pkg::cmd_t       r_mem [FIFO_N];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [OCC_W-1:0]   w_occ_nxt;

    logic w_load, w_fifo_ne, w_in_pri, w_sel_in, w_sel_fifo;
    logic w_push, w_pop, w_in_xfer;

    // Ingress readiness is decided without looking at in_vld, so in_rdy has no in_vld path.
    assign w_load     = ~issue_vld_r | issue_accept;
    assign w_fifo_ne  = (occ_r != '0);
    assign w_in_pri   = (r_state == PRI_IN) | ~w_fifo_ne;
    assign w_sel_in   = in_vld & w_in_pri;
    assign w_sel_fifo = w_fifo_ne & ~w_sel_in;

    assign mtr_accept = ~full_r & ~flush;
    assign in_rdy     = w_load & ~flush & w_in_pri;
    assign w_push     = mtr_vld_r & mtr_accept;
    assign w_pop      = w_load & w_sel_fifo & ~flush;
    assign w_in_xfer  = in_vld & in_rdy;

    always_comb begin
        w_occ_nxt = occ_r;
        if (w_push && !w_pop)
            w_occ_nxt = occ_r + 1'b1;
        else if (!w_push && w_pop)
            w_occ_nxt = occ_r - 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (flush) begin
            w_state_nxt = PRI_MTR;
            w_cnt_nxt   = '0;
        end else if (w_in_xfer) begin
            w_state_nxt = PRI_MTR;
            w_cnt_nxt   = '0;
        end else if ((r_state == PRI_MTR) && w_pop && in_vld) begin
            // Ingress was waiting while the FIFO took the slot.
            w_cnt_nxt = r_cnt + 1'b1;
            if (w_cnt_nxt == CNT_W'(STARVE_MAX))
                w_state_nxt = PRI_IN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= PRI_MTR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= mtr_r;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            occ_r    <= '0;
            full_r   <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            occ_r  <= w_occ_nxt;
            full_r <= (w_occ_nxt == OCC_W'(FIFO_N));
        end
    end

    // Output register: command holds when not loaded, valid drops on flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_vld_r <= 1'b0;
            issue_cmd_r <= '0;
        end else if (flush) begin
            issue_vld_r <= 1'b0;
        end else if (w_load) begin
            issue_vld_r <= w_sel_in | w_sel_fifo;
            if (w_sel_in)
                issue_cmd_r <= in_cmd;
            else if (w_sel_fifo)
                issue_cmd_r <= r_mem[r_rd_ptr];
        end
    end
endmodule
